// File: rtl/eco32_uart_tx_pkg.sv
// eco32_uart_tx_pkg
// Shared definitions for the UART TX packet deformatter:
//   - completion event command code
//   - flit layout (sof flag above the 72-bit ring payload)
//   - header byte-count field position
//   - completion event pointer bit positions and a packing helper
//   - FSM state encoding
package eco32_uart_tx_pkg;

    localparam logic [7:0]  TX_DONE_CMD  = 8'h04;

    localparam int unsigned UL_DATA_W    = 72;
    localparam int unsigned FLIT_W       = UL_DATA_W + 1;
    localparam int unsigned FLIT_SOF_BIT = UL_DATA_W;
    localparam int unsigned PAYLOAD_W    = 64;

    localparam int unsigned HDR_CNT_LSB  = 0;
    localparam int unsigned HDR_CNT_W    = 12;

    localparam int unsigned EVE_PTR_W    = 36;
    localparam int unsigned PTR_OVF_BIT  = 35;
    localparam int unsigned PTR_ERR_BIT  = 34;
    localparam int unsigned PTR_STAT_LSB = 18;
    localparam int unsigned PTR_STAT_W   = 16;
    localparam int unsigned PTR_SENT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_EVENT,
        ST_DRAIN
    } tx_state_e;

    function automatic logic [EVE_PTR_W-1:0] build_eve_ptr(
        input logic                  ovf,
        input logic                  err,
        input logic [PTR_STAT_W-1:0] stat,
        input logic [HDR_CNT_W-1:0]  sent
    );
        logic [EVE_PTR_W-1:0] p;
        p = '0;
        p[PTR_OVF_BIT]                     = ovf;
        p[PTR_ERR_BIT]                     = err;
        p[PTR_STAT_LSB +: PTR_STAT_W]      = stat;
        p[PTR_SENT_LSB +: HDR_CNT_W]       = sent;
        return p;
    endfunction

endpackage

// File: rtl/eco32_flit_fifo.sv
// eco32_flit_fifo
// Synchronous first-word-fall-through FIFO for ring flits.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    push request and data
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry (valid while !empty)
//   empty, full       status
//   count             current occupancy
//   count_nxt         occupancy after the current cycle's push/pop
//   drop              push refused because the FIFO stayed full
module eco32_flit_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 73,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic [AW:0]      count_nxt,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign drop  = wr_en && !wr_ok;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/eco32_uart_tx_pktdeform.sv
// eco32_uart_tx_pktdeform
// Takes packets from the upstream ring, buffers the flits and serialises the
// payload bytes onto the byte handshake feeding the serial transmitter. Each
// packet with a non-zero byte count finishes with a completion event.
// Optional build macro: ETH_TX_PKT_STATS_EN adds a 16-bit completed-event
// counter reported in dl_eve_ptr[33:18] (value before increment).
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   ul_stb, ul_sof, ul_data[71:0]   ring flit input (sof marks header)
//   ul_af[1:0]                      [0] almost full, [1] full (registered)
//   tx_stb, tx_data[7:0], tx_ack    byte output handshake
//   dl_eve_stb, dl_eve_ack          completion event handshake
//   dl_eve_cmd, dl_eve_dev          constant event command / destination
//   dl_eve_ptr[35:0]                {ovf, err, stats/zero, sent[11:0]}
module eco32_uart_tx_pktdeform
    import eco32_uart_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned AF_MARGIN   = 4,
    parameter logic [7:0]  EVE_DEST    = 8'hFF,
    parameter logic [7:0]  CMD_TX_DONE = TX_DONE_CMD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ul_stb,
    input  logic                 ul_sof,
    input  logic [UL_DATA_W-1:0] ul_data,
    output logic [1:0]           ul_af,
    output logic                 tx_stb,
    output logic [7:0]           tx_data,
    input  logic                 tx_ack,
    output logic                 dl_eve_stb,
    output logic [7:0]           dl_eve_cmd,
    output logic [7:0]           dl_eve_dev,
    output logic [EVE_PTR_W-1:0] dl_eve_ptr,
    input  logic                 dl_eve_ack
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] MARGIN_C = (AW+1)'(AF_MARGIN);

    logic [FLIT_W-1:0]     head;
    logic                  head_sof;
    logic [HDR_CNT_W-1:0]  head_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [AW:0]           fifo_count;
    logic [AW:0]           fifo_count_nxt;
    logic                  fifo_drop;
    logic                  fifo_pop;

    tx_state_e             state;
    logic [PAYLOAD_W-1:0]  shreg;
    logic [HDR_CNT_W-1:0]  rem_cnt;
    logic [HDR_CNT_W-1:0]  sent_cnt;
    logic [2:0]            idx;
    logic                  err;
    logic                  ovf;
    logic [PTR_STAT_W-1:0] stat_val;
    logic                  eve_done;

    eco32_flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en     (ul_stb),
        .wr_data   ({ul_sof, ul_data}),
        .rd_en     (fifo_pop),
        .rd_data   (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt),
        .drop      (fifo_drop)
    );

    assign head_sof = head[FLIT_SOF_BIT];
    assign head_cnt = head[HDR_CNT_LSB +: HDR_CNT_W];
    assign eve_done = dl_eve_stb && dl_eve_ack;

    // Headers are consumed in IDLE; LOAD and DRAIN only ever consume data flits
    // so a header that shows up there is left for the next packet.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE:  fifo_pop = !fifo_empty;
            ST_LOAD:  fifo_pop = !fifo_empty && !head_sof;
            ST_DRAIN: fifo_pop = !fifo_empty && !head_sof;
            default:  fifo_pop = 1'b0;
        endcase
    end

    // Registered from the next occupancy so the flags line up with the
    // occupancy reached by the write/read of the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ul_af <= '0;
        end else begin
            ul_af <= {fifo_count_nxt == DEPTH_C,
                      (DEPTH_C - fifo_count_nxt) <= MARGIN_C};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            rem_cnt    <= '0;
            sent_cnt   <= '0;
            idx        <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            tx_stb     <= 1'b0;
            dl_eve_stb <= 1'b0;
        end else begin
            // A drop coinciding with an event accept stays recorded for the next event.
            if (fifo_drop) begin
                ovf <= 1'b1;
            end else if (eve_done) begin
                ovf <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && head_sof) begin
                        rem_cnt  <= head_cnt;
                        sent_cnt <= '0;
                        if (head_cnt != '0) begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (!fifo_empty) begin
                        if (!head_sof) begin
                            shreg  <= head[PAYLOAD_W-1:0];
                            idx    <= '0;
                            tx_stb <= 1'b1;
                            state  <= ST_SEND;
                        end else begin
                            err        <= 1'b1;
                            dl_eve_stb <= 1'b1;
                            state      <= ST_EVENT;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_ack) begin
                        shreg    <= shreg >> 8;
                        rem_cnt  <= rem_cnt - HDR_CNT_W'(1);
                        sent_cnt <= sent_cnt + HDR_CNT_W'(1);
                        idx      <= idx + 3'd1;
                        if (rem_cnt == HDR_CNT_W'(1)) begin
                            tx_stb     <= 1'b0;
                            dl_eve_stb <= 1'b1;
                            state      <= ST_EVENT;
                        end else if (idx == 3'd7) begin
                            tx_stb <= 1'b0;
                            state  <= ST_LOAD;
                        end
                    end
                end
                ST_EVENT: begin
                    if (dl_eve_ack) begin
                        dl_eve_stb <= 1'b0;
                        err        <= 1'b0;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty || head_sof) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ETH_TX_PKT_STATS_EN
    logic [PTR_STAT_W-1:0] ev_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_cnt <= '0;
        end else if (eve_done) begin
            ev_cnt <= ev_cnt + PTR_STAT_W'(1);
        end
    end

    assign stat_val = ev_cnt;
`else
    assign stat_val = '0;
`endif

    assign tx_data    = shreg[7:0];
    assign dl_eve_cmd = CMD_TX_DONE;
    assign dl_eve_dev = EVE_DEST;
    assign dl_eve_ptr = dl_eve_stb ? build_eve_ptr(ovf, err, stat_val, sent_cnt) : '0;

    logic unused_sigs;
    assign unused_sigs = ^{head[UL_DATA_W-1:PAYLOAD_W], fifo_full, fifo_count};

endmodule

// File: tb/tb_eco32_uart_tx_pktdeform.sv
module tb_eco32_uart_tx_pktdeform;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ul_stb = 1'b0;
    logic        ul_sof = 1'b0;
    logic [71:0] ul_data = '0;
    logic [1:0]  ul_af;
    logic        tx_stb;
    logic [7:0]  tx_data;
    logic        tx_ack = 1'b0;
    logic        dl_eve_stb;
    logic [7:0]  dl_eve_cmd;
    logic [7:0]  dl_eve_dev;
    logic [35:0] dl_eve_ptr;
    logic        dl_eve_ack = 1'b0;

    eco32_uart_tx_pktdeform #(
        .FIFO_DEPTH  (16),
        .AF_MARGIN   (4),
        .EVE_DEST    (8'hFF),
        .CMD_TX_DONE (8'h04)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ul_stb     (ul_stb),
        .ul_sof     (ul_sof),
        .ul_data    (ul_data),
        .ul_af      (ul_af),
        .tx_stb     (tx_stb),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .dl_eve_stb (dl_eve_stb),
        .dl_eve_cmd (dl_eve_cmd),
        .dl_eve_dev (dl_eve_dev),
        .dl_eve_ptr (dl_eve_ptr),
        .dl_eve_ack (dl_eve_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ovf;
        bit          err;
        int unsigned sent;
    } ev_t;

    logic [7:0]  exp_bytes[$];
    ev_t         exp_evs[$];
    int unsigned acc_cyc[$];
    int unsigned cyc = 0;
    int unsigned last_hdr_cyc = 0;
    int unsigned ev_count = 0;
    int          total = 0;
    int          bad = 0;
    int          tx_mode = 0;   // 0 ack high, 1 toggle, 2 random, 3 held low
    int          eve_mode = 0;  // 0 ack high, 1 random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int unsigned act);
        total++;
        bad++;
        $display("FAIL %s got=%0d required=none", name, act);
    endtask

    // Acknowledge drivers, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ack = 1'b1;
                1:       tx_ack = ~tx_ack;
                2:       tx_ack = ($urandom_range(0, 3) != 0);
                default: tx_ack = 1'b0;
            endcase
            dl_eve_ack = (eve_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake.
    initial begin
        logic        pend;
        logic [7:0]  pend_data;
        logic [35:0] req_ptr;
        ev_t         e;
        pend = 1'b0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (tx_stb && pend) check("tx_hold", 64'(tx_data), 64'(pend_data));
                pend = tx_stb && !tx_ack;
                pend_data = tx_data;
                if (tx_stb && tx_ack) begin
                    acc_cyc.push_back(cyc);
                    if (exp_bytes.size() == 0) fail_now("tx_unexpected_byte", int'(tx_data));
                    else check("tx_byte", 64'(tx_data), 64'(exp_bytes.pop_front()));
                end
                if (dl_eve_stb && dl_eve_ack) begin
                    if (exp_evs.size() == 0) begin
                        fail_now("eve_unexpected", int'(dl_eve_ptr[11:0]));
                    end else begin
                        e = exp_evs.pop_front();
                        req_ptr = '0;
                        req_ptr[35] = e.ovf;
                        req_ptr[34] = e.err;
                        req_ptr[11:0] = e.sent[11:0];
`ifdef ETH_TX_PKT_STATS_EN
                        req_ptr[33:18] = ev_count[15:0];
`endif
                        check("eve_ptr", 64'(dl_eve_ptr), 64'(req_ptr));
                        check("eve_cmd", 64'(dl_eve_cmd), 64'h04);
                        check("eve_dev", 64'(dl_eve_dev), 64'hFF);
                    end
                    ev_count++;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    function automatic logic [71:0] rand_flit();
        logic [71:0] d;
        d[31:0]  = $urandom();
        d[63:32] = $urandom();
        d[71:64] = 8'($urandom());
        return d;
    endfunction

    // Called just after a rising edge; returns just after the write edge.
    task automatic put(input bit sof, input logic [71:0] d, input bit fc);
        int unsigned guard;
        guard = 0;
        if (fc) begin
            while (ul_af[0] && guard < 5000) begin
                ul_stb = 1'b0;
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 5000) fail_now("put_flow_timeout", guard);
        end
        ul_stb  = 1'b1;
        ul_sof  = sof;
        ul_data = d;
        @(posedge clk);
        #1;
        ul_stb = 1'b0;
        ul_sof = 1'b0;
    endtask

    task automatic push_bytes(input logic [71:0] d, input int unsigned nb);
        for (int unsigned b = 0; b < nb && b < 8; b++) exp_bytes.push_back(d[8*b +: 8]);
    endtask

    // Packet-level reference: a header with count n, nfl data flits, surplus
    // extra data flits. Bytes emitted are the first min(n, 8*nfl) payload
    // bytes; an event follows for n>0, flagged err when the packet was cut short.
    task automatic send_packet(input int unsigned n, input int unsigned nfl,
                               input int unsigned surplus, input bit ovf,
                               input bit use_fixed, input logic [63:0] fixed);
        logic [71:0] d;
        int unsigned need;
        int unsigned got;
        ev_t e;
        need = (n + 7) / 8;
        d = rand_flit();
        d[11:0] = n[11:0];
        put(1'b1, d, 1'b1);
        last_hdr_cyc = cyc;
        for (int unsigned f = 0; f < nfl + surplus; f++) begin
            d = rand_flit();
            if (use_fixed) d[63:0] = fixed;
            put(1'b0, d, 1'b1);
            if (f < nfl && f * 8 < n) push_bytes(d, n - f * 8);
        end
        if (n > 0) begin
            got = (8 * nfl < n) ? 8 * nfl : n;
            e.ovf = ovf;
            e.err = (nfl < need);
            e.sent = got;
            exp_evs.push_back(e);
        end
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned k;
        k = 0;
        while ((exp_bytes.size() != 0 || exp_evs.size() != 0) && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= limit) fail_now("wait_idle_timeout", exp_bytes.size() + exp_evs.size());
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input int unsigned limit);
        int unsigned k;
        k = 0;
        while (!tx_stb && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= limit) fail_now("wait_stb_timeout", k);
    endtask

    initial begin
        logic [71:0] d;
        int unsigned n;
        int unsigned need;
        int unsigned r;
        bit          trunc;
        ev_t         e;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_stb", 64'(tx_stb), 64'h0);
        check("rst_tx_data", 64'(tx_data), 64'h0);
        check("rst_eve_stb", 64'(dl_eve_stb), 64'h0);
        check("rst_eve_ptr", 64'(dl_eve_ptr), 64'h0);
        check("rst_ul_af", 64'(ul_af), 64'h0);
        check("rst_eve_cmd", 64'(dl_eve_cmd), 64'h04);
        check("rst_eve_dev", 64'(dl_eve_dev), 64'hFF);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // N=3, bytes AA BB CC back to back, two-cycle latency from header write
        tx_mode = 0;
        eve_mode = 0;
        acc_cyc.delete();
        send_packet(3, 1, 0, 1'b0, 1'b1, 64'h0000_0000_00CC_BBAA);
        wait_idle(200);
        check("t1_nbytes", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) begin
            check("t1_latency", 64'(acc_cyc[0] - last_hdr_cyc), 64'd2);
            check("t1_back_to_back", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);
        end

        // N=10 over two flits with a toggling ack
        tx_mode = 1;
        send_packet(10, 2, 0, 1'b0, 1'b0, '0);
        wait_idle(400);

        // N=16 truncated after one flit by the next header, which then runs normally
        tx_mode = 2;
        send_packet(16, 1, 0, 1'b0, 1'b0, '0);
        send_packet(5, 1, 0, 1'b0, 1'b0, '0);
        wait_idle(400);

        // N=2 with a surplus data flit, then an ordinary packet
        tx_mode = 0;
        send_packet(2, 1, 1, 1'b0, 1'b0, '0);
        send_packet(9, 2, 0, 1'b0, 1'b0, '0);
        wait_idle(400);

        // Overflow: stall in SEND, then write 20 flits into the empty 16-deep FIFO
        tx_mode = 3;
        @(posedge clk);
        #1;
        d = rand_flit();
        d[11:0] = 12'd200;
        put(1'b1, d, 1'b1);
        d = rand_flit();
        put(1'b0, d, 1'b1);
        push_bytes(d, 8);
        wait_stb(50);
        check("ovf_pre_af", 64'(ul_af), 64'h0);
        for (int unsigned k = 1; k <= 20; k++) begin
            d = rand_flit();
            put(1'b0, d, 1'b0);
            if (k <= 16) push_bytes(d, 8);
            check("ovf_ul_af", 64'(ul_af),
                  64'({(k >= 16) ? 1'b1 : 1'b0, (k >= 12) ? 1'b1 : 1'b0}));
        end
        tx_mode = 0;
        for (int unsigned k = 0; k < 8; k++) begin
            d = rand_flit();
            put(1'b0, d, 1'b1);
            push_bytes(d, 8);
        end
        e.ovf = 1'b1;
        e.err = 1'b0;
        e.sent = 200;
        exp_evs.push_back(e);
        send_packet(1, 1, 0, 1'b0, 1'b0, '0);
        wait_idle(1000);

        // Asynchronous reset in the middle of SEND
        tx_mode = 3;
        d = rand_flit();
        d[11:0] = 12'd40;
        put(1'b1, d, 1'b1);
        for (int unsigned k = 0; k < 5; k++) put(1'b0, rand_flit(), 1'b1);
        wait_stb(50);
        check("pre_rst_tx_stb", 64'(tx_stb), 64'h1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_tx_stb", 64'(tx_stb), 64'h0);
        check("mid_rst_eve_stb", 64'(dl_eve_stb), 64'h0);
        check("mid_rst_ul_af", 64'(ul_af), 64'h0);
        exp_bytes.delete();
        exp_evs.delete();
        ev_count = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tx_mode = 0;
        acc_cyc.delete();
        send_packet(1, 1, 0, 1'b0, 1'b0, '0);
        wait_idle(200);
        check("post_rst_nbytes", 64'(acc_cyc.size()), 64'd1);

        // Randomised packets: random counts, truncation, surplus flits, acks
        tx_mode = 2;
        eve_mode = 1;
        trunc = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            n = $urandom_range(0, 60);
            need = (n + 7) / 8;
            r = $urandom_range(0, 5);
            if (r == 0 && need > 0) begin
                send_packet(n, $urandom_range(0, need - 1), 0, 1'b0, 1'b0, '0);
                trunc = 1'b1;
            end else if (r == 1) begin
                send_packet(n, need, $urandom_range(1, 2), 1'b0, 1'b0, '0);
                trunc = 1'b0;
            end else begin
                send_packet(n, need, 0, 1'b0, 1'b0, '0);
                trunc = 1'b0;
            end
        end
        if (trunc) send_packet(1, 1, 0, 1'b0, 1'b0, '0);
        wait_idle(5000);

        // Largest legal count
        tx_mode = 0;
        eve_mode = 0;
        send_packet(4095, 512, 0, 1'b0, 1'b0, '0);
        wait_idle(20000);

        check("end_bytes_left", 64'(exp_bytes.size()), 64'd0);
        check("end_events_left", 64'(exp_evs.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
